mod_count_seq_monitor: RTL and testbench
========================================

// Module: mod_count_seq_monitor
// PURPOSE
//  Downstream checker for the 3-bit synchronous JK counter outputs {q2,q1,q0}.
//  Samples the count on sample_en and verifies each new value is the previous value
//  +1 mod 2^WIDTH (or unchanged). Flags and counts sequence errors and wrap events.
//  Reports lock status to board-level status LEDs / debug logic.
// PARAMETERS
//  WIDTH       3  width of monitored count (q_in)
//  LOCK_COUNT  2  consecutive good +1 steps needed to reach LOCKED (>=1)
//  ERR_CNT_W   8  width of err_count (saturating)
//  WRAP_CNT_W  8  width of wrap_count (free-running, wraps mod 2^WRAP_CNT_W)
// PORTS
//  clk         in   1           clock, same domain as the counter
//  rst         in   1           synchronous reset, active-high
//  sample_en   in   1           1 = q_in valid this cycle, take a sample
//  q_in        in   WIDTH       monitored count, q_in[2]=q2 ... q_in[0]=q0
//  locked      out  1           1 while FSM in LOCKED
//  err_pulse   out  1           1-cycle pulse: sequence error detected in LOCKED
//  wrap_pulse  out  1           1-cycle pulse: max->0 step detected in LOCKED
//  err_count   out  ERR_CNT_W   number of errors, saturates at all-ones
//  wrap_count  out  WRAP_CNT_W  number of wraps, rolls over
//  err_sticky  out  1           only when SEQ_MON_STICKY_ERR_EN defined
// BEHAVIOUR
//  - All outputs registered. Reset (rst=1 at posedge clk): state=IDLE, prev=0, good_cnt=0,
//    locked=0, err_pulse=0, wrap_pulse=0, err_count=0, wrap_count=0 (err_sticky=0).
//  - rst has priority over sample_en; reset mid-operation discards prev and lock.
//  - Latency: sample at edge N -> pulses/counters/locked updated at edge N (visible after N),
//    i.e. 1 cycle from sample_en/q_in presentation. Pulses deassert next cycle unless re-fired.
//  - sample_en=0: no state, prev or counter change; pulses forced 0.
//  - prev <= q_in on every accepted sample in every state.
//  - nxt = (prev + 1) mod 2^WIDTH (WIDTH-bit add, carry dropped). stall = (q_in == prev).
//  - FSM:
//    IDLE:    sample -> ACQUIRE, good_cnt=0. No error/wrap evaluation.
//    ACQUIRE: q_in==nxt -> good_cnt+1; if good_cnt+1==LOCK_COUNT -> LOCKED, good_cnt=0.
//             stall -> no change. other -> good_cnt=0, stay. Never pulses err/wrap.
//    LOCKED:  q_in==nxt -> stay; if prev==2^WIDTH-1 (q_in==0): wrap_pulse=1, wrap_count+1.
//             stall -> stay, no pulse. other -> err_pulse=1, err_count+1 (sat), -> ACQUIRE,
//             good_cnt=0.
//  - err_count at all-ones: err_pulse still fires, count holds.
//  - wrap_count at all-ones + wrap -> 0.
//  - Step into LOCKED is never itself a wrap/err event even if it is the max->0 step.
// CONFIGURATION
//  - SEQ_MON_STICKY_ERR_EN defined: err_sticky output present; set to 1 on first err_pulse
//    (same edge), held until rst. Not cleared by re-lock.
//  - Not defined: err_sticky port and logic absent; all other behaviour identical.
// TESTING
//  1 rst=1 3 cycles, sample_en=1 q_in=5 -> all outputs 0, state IDLE after release.
//  2 sample_en=1 every cycle, q_in 0,1,2,3..7,0,1 (LOCK_COUNT=2) -> locked=1 after sample
//    of 2; wrap_pulse=1 one cycle after q_in 0 follows 7, wrap_count=1; err_count=0.
//  3 locked, q_in 3 then 5 -> err_pulse 1 cycle, err_count=1, locked=0; then 6,7 -> locked=1.
//  4 locked, q_in 4,4,4,5 and sample_en=0 gaps with garbage q_in -> no err, locked stays 1.
//  5 ERR_CNT_W=2, force 5 errors (re-locking between) -> err_count 1,2,3,3,3; 5 err_pulses.
//  6 rst=1 mid LOCKED with err_count=2 -> all 0 next cycle; macro on: err_sticky=1 after
//    first error, stays 1 through re-lock, 0 only after rst.

Source files
------------

// File: rtl/mod_count_seq_monitor.sv
// -----------------------------------------------------------------------------
// mod_count_seq_monitor
//
// Watches the output of a free-running modulo-2^WIDTH up-counter. On each
// accepted sample it checks that the new count is either the previous count
// + 1 (mod 2^WIDTH) or unchanged (a stall).
//
// A small FSM (IDLE -> ACQUIRE -> LOCKED) only declares lock after
// LOCK_COUNT consecutive good +1 steps. Once locked, it reports:
//   - sequence errors, which also drop it back to ACQUIRE
//   - max->0 wrap events
//
// Optional feature, enabled by the macro SEQ_MON_STICKY_ERR_EN:
//   Adds the err_sticky output. err_sticky latches the first error and
//   holds until rst.
//
// Parameters:
//   WIDTH       width of the monitored count
//   LOCK_COUNT  consecutive good +1 steps needed to lock (>= 1)
//   ERR_CNT_W   width of err_count (saturating)
//   WRAP_CNT_W  width of wrap_count (rolls over)
//
// Ports:
//   clk         clock, same domain as the monitored counter
//   rst         synchronous reset, active-high, priority over sample_en
//   sample_en   q_in is valid this cycle; take a sample
//   q_in        monitored count
//   locked      1 while the FSM is in LOCKED
//   err_pulse   one-cycle pulse on a sequence error seen while locked
//   wrap_pulse  one-cycle pulse on a max->0 step seen while locked
//   err_count   number of errors, saturates at all-ones
//   wrap_count  number of wraps, rolls over
//   err_sticky  (SEQ_MON_STICKY_ERR_EN only) set by first error, held to rst
//
// All outputs are registered and update on the same edge that takes the
// sample.
// -----------------------------------------------------------------------------
module mod_count_seq_monitor #(
  parameter int WIDTH      = 3,
  parameter int LOCK_COUNT = 2,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_en,
  input  logic [WIDTH-1:0]      q_in,
  output logic                  locked,
  output logic                  err_pulse,
  output logic                  wrap_pulse,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [WRAP_CNT_W-1:0] wrap_count
`ifdef SEQ_MON_STICKY_ERR_EN
  ,
  output logic                  err_sticky
`endif
);

  // good_cnt never exceeds LOCK_COUNT, so size it to hold that value.
  localparam int GC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [GC_W-1:0] LOCK_TGT = GC_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        prev_q, prev_d;
  logic [GC_W-1:0]         good_q, good_d;
  logic                    err_pulse_d, wrap_pulse_d;
  logic [ERR_CNT_W-1:0]    err_count_d;
  logic [WRAP_CNT_W-1:0]   wrap_count_d;

  logic [WIDTH-1:0]        nxt;
  logic [GC_W-1:0]         good_inc;
  logic                    step_ok;
  logic                    stall;

  // The add is WIDTH bits wide, so the carry out of the top bit is dropped.
  // This makes max+1 equal 0, which is exactly a counter wrap.
  assign nxt      = prev_q + WIDTH'(1);
  assign good_inc = good_q + GC_W'(1);
  assign step_ok  = (q_in == nxt);
  assign stall    = (q_in == prev_q);

  always_comb begin
    // NOTE: every signal driven here gets a default before any branch.
    // Without that, a path that skips an assignment would infer a latch.
    state_d      = state_q;
    prev_d       = prev_q;
    good_d       = good_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    err_count_d  = err_count;
    wrap_count_d = wrap_count;

    if (sample_en) begin
      prev_d = q_in;
      unique case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
        ACQUIRE: begin
          if (step_ok) begin
            if (good_inc == LOCK_TGT) begin
              // Entering LOCKED is never reported as a wrap or an error,
              // even when this step is the max->0 step.
              state_d = LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_inc;
            end
          end else if (!stall) begin
            good_d = '0;
          end
        end
        LOCKED: begin
          if (step_ok) begin
            if (prev_q == '1) begin
              wrap_pulse_d = 1'b1;
              wrap_count_d = wrap_count + WRAP_CNT_W'(1);
            end
          end else if (!stall) begin
            err_pulse_d = 1'b1;
            if (err_count != '1) begin
              err_count_d = err_count + ERR_CNT_W'(1);
            end
            state_d = ACQUIRE;
            good_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
          good_d  = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then updates from its pre-edge value, whatever order the
  // statements are written in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      good_q     <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      good_q     <= good_d;
      // Registered from the next state so that lock status changes on the
      // same edge as the sample that caused it.
      locked     <= (state_d == LOCKED);
      err_pulse  <= err_pulse_d;
      wrap_pulse <= wrap_pulse_d;
      err_count  <= err_count_d;
      wrap_count <= wrap_count_d;
    end
  end

`ifdef SEQ_MON_STICKY_ERR_EN
  // Re-locking does not clear err_sticky; only rst does.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (err_pulse_d) begin
      err_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mod_count_seq_monitor.sv
// -----------------------------------------------------------------------------
// tb_mod_count_seq_monitor
//
// Directed bench for mod_count_seq_monitor.
//
// DUT configuration:
//   WIDTH=3, LOCK_COUNT=2
//   ERR_CNT_W=2 and WRAP_CNT_W=2, so that err_count saturation and
//   wrap_count rollover are reached after only a few events.
//
// The expected value at every check point is worked out by hand from the
// sample history written just above it.
//
// Build with SEQ_MON_STICKY_ERR_EN defined to also check err_sticky.
// -----------------------------------------------------------------------------
module tb_mod_count_seq_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic [2:0] q_in;
  logic       locked;
  logic       err_pulse;
  logic       wrap_pulse;
  logic [1:0] err_count;
  logic [1:0] wrap_count;
`ifdef SEQ_MON_STICKY_ERR_EN
  logic       err_sticky;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mod_count_seq_monitor #(
    .WIDTH      (3),
    .LOCK_COUNT (2),
    .ERR_CNT_W  (2),
    .WRAP_CNT_W (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .q_in       (q_in),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .wrap_pulse (wrap_pulse),
    .err_count  (err_count),
    .wrap_count (wrap_count)
`ifdef SEQ_MON_STICKY_ERR_EN
    ,
    .err_sticky (err_sticky)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic chk(input string tag, input logic lk, input logic ep,
                     input logic wp, input logic [1:0] ec,
                     input logic [1:0] wc);
    check({tag, ".locked"},     locked,     lk);
    check({tag, ".err_pulse"},  err_pulse,  ep);
    check({tag, ".wrap_pulse"}, wrap_pulse, wp);
    check({tag, ".err_count"},  err_count,  ec);
    check({tag, ".wrap_count"}, wrap_count, wc);
  endtask

  task automatic chk_sticky(input string tag, input logic exp_val);
`ifdef SEQ_MON_STICKY_ERR_EN
    check({tag, ".err_sticky"}, err_sticky, exp_val);
`endif
  endtask

  // Drives the inputs, lets one rising edge take them, then waits 1 time
  // unit so the outputs are read away from the edge.
  task automatic smp(input logic en, input logic [2:0] q);
    sample_en = en;
    q_in      = q;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    sample_en = 1'b0;
    q_in      = '0;
    #1;

    // 1: reset has priority over a live sample.
    smp(1'b1, 3'd5);
    smp(1'b1, 3'd5);
    smp(1'b1, 3'd5);
    chk("rst_hold", 0, 0, 0, 2'd0, 2'd0);
    chk_sticky("rst_hold", 0);
    rst = 1'b0;
    smp(1'b0, 3'd5);
    chk("idle_noen", 0, 0, 0, 2'd0, 2'd0);

    // 2: count up and lock on the sample of 2, then wrap 7->0.
    smp(1'b1, 3'd0);
    chk("t2_s0", 0, 0, 0, 2'd0, 2'd0);
    smp(1'b1, 3'd1);
    chk("t2_s1", 0, 0, 0, 2'd0, 2'd0);
    smp(1'b1, 3'd2);
    chk("t2_lock", 1, 0, 0, 2'd0, 2'd0);
    for (int q = 3; q <= 7; q++) begin
      smp(1'b1, 3'(q));
    end
    chk("t2_s7", 1, 0, 0, 2'd0, 2'd0);
    smp(1'b1, 3'd0);
    chk("t2_wrap", 1, 0, 1, 2'd0, 2'd1);
    smp(1'b1, 3'd1);
    chk("t2_after_wrap", 1, 0, 0, 2'd0, 2'd1);

    // 3: 3 -> 5 is an error. The next two good steps (6, 7) re-lock.
    smp(1'b1, 3'd2);
    smp(1'b1, 3'd3);
    chk("t3_pre", 1, 0, 0, 2'd0, 2'd1);
    smp(1'b1, 3'd5);
    chk("t3_err", 0, 1, 0, 2'd1, 2'd1);
    chk_sticky("t3_err", 1);
    smp(1'b1, 3'd6);
    chk("t3_acq", 0, 0, 0, 2'd1, 2'd1);
    smp(1'b1, 3'd7);
    chk("t3_relock", 1, 0, 0, 2'd1, 2'd1);
    chk_sticky("t3_relock", 1);

    // 4: a wrap, then a gap (the pulse must drop), then stalls and more
    //    gaps with garbage on q_in.
    smp(1'b1, 3'd0);
    chk("t4_wrap", 1, 0, 1, 2'd1, 2'd2);
    smp(1'b0, 3'd3);
    chk("t4_gap_after_wrap", 1, 0, 0, 2'd1, 2'd2);
    smp(1'b1, 3'd1);
    smp(1'b1, 3'd2);
    smp(1'b1, 3'd3);
    smp(1'b1, 3'd4);
    smp(1'b1, 3'd4);
    chk("t4_stall", 1, 0, 0, 2'd1, 2'd2);
    smp(1'b1, 3'd4);
    smp(1'b0, 3'd6);
    smp(1'b0, 3'd2);
    chk("t4_gaps", 1, 0, 0, 2'd1, 2'd2);
    smp(1'b1, 3'd5);
    chk("t4_step", 1, 0, 0, 2'd1, 2'd2);

    // 5: four more errors, re-locking in between. err_count goes 2, 3,
    //    then holds at 3. The re-lock 7->0 is not counted as a wrap.
    smp(1'b1, 3'd0);
    chk("t5_err_a", 0, 1, 0, 2'd2, 2'd2);
    smp(1'b1, 3'd1);
    smp(1'b1, 3'd2);
    chk("t5_lock_a", 1, 0, 0, 2'd2, 2'd2);
    smp(1'b1, 3'd6);
    chk("t5_err_b", 0, 1, 0, 2'd3, 2'd2);
    smp(1'b1, 3'd7);
    smp(1'b1, 3'd0);
    chk("t5_lock_on_wrap", 1, 0, 0, 2'd3, 2'd2);
    smp(1'b1, 3'd4);
    chk("t5_err_c_sat", 0, 1, 0, 2'd3, 2'd2);
    smp(1'b1, 3'd5);
    smp(1'b1, 3'd6);
    smp(1'b1, 3'd1);
    chk("t5_err_d_sat", 0, 1, 0, 2'd3, 2'd2);
    smp(1'b1, 3'd2);
    smp(1'b1, 3'd3);
    chk("t5_lock_d", 1, 0, 0, 2'd3, 2'd2);

    // wrap_count rolls over from 3 to 0.
    for (int q = 4; q <= 7; q++) begin
      smp(1'b1, 3'(q));
    end
    smp(1'b1, 3'd0);
    chk("wrap_to3", 1, 0, 1, 2'd3, 2'd3);
    for (int q = 1; q <= 7; q++) begin
      smp(1'b1, 3'(q));
    end
    smp(1'b1, 3'd0);
    chk("wrap_roll", 1, 0, 1, 2'd3, 2'd0);

    // 6: reset while locked clears everything, including err_sticky.
    rst = 1'b1;
    smp(1'b1, 3'd3);
    rst = 1'b0;
    chk("t6_rst_a", 0, 0, 0, 2'd0, 2'd0);
    chk_sticky("t6_rst_a", 0);
    smp(1'b1, 3'd0);
    smp(1'b1, 3'd1);
    smp(1'b1, 3'd2);
    smp(1'b1, 3'd4);
    chk("t6_err1", 0, 1, 0, 2'd1, 2'd0);
    smp(1'b1, 3'd5);
    smp(1'b1, 3'd6);
    smp(1'b1, 3'd0);
    chk("t6_err2", 0, 1, 0, 2'd2, 2'd0);
    smp(1'b1, 3'd1);
    smp(1'b1, 3'd2);
    chk("t6_locked", 1, 0, 0, 2'd2, 2'd0);
    chk_sticky("t6_locked", 1);
    rst = 1'b1;
    smp(1'b1, 3'd3);
    rst = 1'b0;
    chk("t6_rst_b", 0, 0, 0, 2'd0, 2'd0);
    chk_sticky("t6_rst_b", 0);

    // Lock is gone after reset: two good steps are needed again.
    smp(1'b1, 3'd4);
    chk("t6_idle_sample", 0, 0, 0, 2'd0, 2'd0);
    smp(1'b1, 3'd5);
    chk("t6_acq", 0, 0, 0, 2'd0, 2'd0);
    smp(1'b1, 3'd6);
    chk("t6_relock", 1, 0, 0, 2'd0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
